edge_detector_array: RTL and testbench
======================================

# edge_detector_array

Multi-channel, parametrised edge detector with per-channel glitch filtering, edge-mode selection, sticky pending flags and saturating event counters. It turns raw or asynchronous level inputs into qualified single-cycle edge pulses, and aggregates them into one interrupt line. It sits between external or cross-domain status lines and the control/interrupt logic.

## Interface
- `CHANNELS`, default 8: number of independent input channels (≥1).
- `FILT_CYCLES`, default 4: consecutive samples a new level must hold before it is accepted (≥1; 1 = no filtering).
- `CNT_W`, default 8: width of each per-channel event counter (≥1).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_edge` in CHANNELS: raw level inputs.
- `mode` in 2*CHANNELS: per-channel `edge_mode_t`, with channel i at bits [2i+1:2i]. 00 OFF, 01 RISE, 10 FALL, 11 BOTH.
- `clr` in CHANNELS: per-channel clear of pending flag and counter.
- `level` out CHANNELS: filtered, accepted level.
- `out_posedge` out CHANNELS: 1-cycle pulse on an accepted rising edge, when enabled by mode.
- `out_negedge` out CHANNELS: 1-cycle pulse on an accepted falling edge, when enabled by mode.
- `pending` out CHANNELS: sticky flag for a qualified edge.
- `evt_cnt` out CHANNELS*CNT_W: saturating count of qualified edges, with channel i at [CNT_W*(i+1)-1:CNT_W*i].
- `irq` out 1: registered OR of `pending`.

## Operation
- Sample stage: `s[i]` registers `in_edge[i]`. With the synchroniser enabled, it is the output of the sync chain instead.
- Filter, per channel: `level` is a register and `fcnt` is a counter of width $clog2(FILT_CYCLES)+1.
  - If `s == level`, then `fcnt` ← 0.
  - Otherwise, if `fcnt == FILT_CYCLES-1`, then `level` ← `s`, `fcnt` ← 0, and the raw edge fires. It is a rise if `s` = 1, otherwise a fall.
  - Otherwise, `fcnt` ← `fcnt` + 1.
  - A glitch shorter than FILT_CYCLES samples never changes `level`.
- Qualified edge:
  - A rise counts only when `mode` bit0 = 1.
  - A fall counts only when `mode` bit1 = 1.
  - OFF: the filter still tracks `level`, but no pulses, pending flags or counts are produced.
  - A `mode` change takes effect on the same cycle it is sampled. It never resets the filter.
- Pending:
  - Set on a qualified edge.
  - Cleared by `clr`.
  - Simultaneous set and `clr`: set wins, so no event is lost.
- Counter:
  - +1 per qualified edge.
  - Saturates at 2^CNT_W-1.
  - `clr` zeroes it.
  - Simultaneous `clr` and event: the counter becomes 1.
- Rise and fall can never coincide on one channel. Channels are fully independent.

## Timing
- Reset values: `level`, `out_posedge`, `out_negedge`, `pending`, `evt_cnt`, `irq`, `fcnt`, `s` and the sync flops are all 0.
- Reset overrides every other input in the same cycle.
- After reset, an input held at 1 is accepted as a rising edge after the normal filter latency. This is intended.
- Latency without sync:
  - Let edge E be the first clock edge at which `in_edge` is sampled at the new value and then held.
  - `level` and the pulse update at edge E+FILT_CYCLES.
- With sync: 2 more cycles of latency.
- `out_posedge` and `out_negedge` are registered and high for exactly 1 cycle.
- `pending` and `evt_cnt` update on the same edge as the pulse.
- `irq` follows `pending` 1 cycle later.
- `clr` acts on the next edge. A `clr` held high holds the counter at 0 and the pending flag low, except in a cycle with an event, where the set-wins rule applies.

## Configuration
- `EDGE_DET_SYNC_EN` defined:
  - Each input passes through a 2-flop synchroniser before the sample stage.
  - Adds 2 cycles of latency.
  - `in_edge` may be asynchronous.
- Not defined:
  - Single sample register only.
  - `in_edge` must be synchronous to `clk`.
- No other behaviour changes.

## Structure
- Package `edge_det_pkg`:
  - `typedef enum logic [1:0] edge_mode_t {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}`.
  - Default values for `CHANNELS`, `FILT_CYCLES` and `CNT_W`.
- Sub-module `edge_det_channel`:
  - Contains sample/sync, filter, pulse, pending and counter logic for one channel.
  - The top generates CHANNELS instances and the `irq` reduction.

## Test plan
- Glitch rejection: FILT_CYCLES=4, no sync, ch0 mode RISE. Drive `in_edge[0]`=1 for 3 cycles, then 0 → `level[0]` stays 0, no pulse, `evt_cnt[0]`=0.
- Acceptance latency: drive `in_edge[0]` 0→1 and hold → `out_posedge[0]` high for exactly 1 cycle, 4 edges after the first sampling edge. `pending[0]`=1, `evt_cnt[0]`=1, and `irq`=1 one cycle later. With `EDGE_DET_SYNC_EN` defined, the pulse comes 6 edges after the first sampling edge.
- Mode gating: ch1 FALL. Drive a 1→0→1 sequence, each level held 10 cycles → only `out_negedge[1]` pulses, `evt_cnt[1]`=1. The same stimulus with mode OFF → no pulses, while `level[1]` still follows the input.
- Saturation: CNT_W=2, mode BOTH, 6 accepted edges → `evt_cnt` reads 1,2,3,3,3,3.
- Clear collision: assert `clr[2]` in the same cycle as a qualified edge → `pending[2]`=1 and `evt_cnt[2]`=1. Then `clr` alone → 0, 0, and `irq` drops 1 cycle later.
- Reset mid-filter: `rst` asserted while `fcnt` is non-zero and `pending` is set → all outputs 0 on the next edge. After release, with the input held at 1 → rising pulse after 4 cycles.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared types and default sizing for the edge_detector_array block.
package edge_det_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int unsigned DEF_CHANNELS    = 8;
    localparam int unsigned DEF_FILT_CYCLES = 4;
    localparam int unsigned DEF_CNT_W       = 8;

endpackage

// File: rtl/edge_det_channel.sv
// One channel: sample (optionally synchronised via EDGE_DET_SYNC_EN), glitch filter,
// mode-qualified edge pulses, sticky pending flag and saturating event counter.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_i,
    input  edge_mode_t       mode_i,
    input  logic             clr_i,
    output logic             level_o,
    output logic             posedge_o,
    output logic             negedge_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam int unsigned FCNT_W = $clog2(FILT_CYCLES) + 1;

    logic              samp_in;
    logic              s_q;
    logic              level_q, level_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              pos_q, pos_d;
    logic              neg_q, neg_d;
    logic              pending_q, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              raw_rise, raw_fall, rise_en, fall_en, evt;

`ifdef EDGE_DET_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], in_i};
    end

    assign samp_in = sync_q[1];
`else
    assign samp_in = in_i;
`endif

    // Filter, qualification, pending and counter next-state
    always_comb begin
        level_d  = level_q;
        fcnt_d   = fcnt_q;
        raw_rise = 1'b0;
        raw_fall = 1'b0;
        if (s_q == level_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FCNT_W'(FILT_CYCLES - 1)) begin
            level_d  = s_q;
            fcnt_d   = '0;
            raw_rise = s_q;
            raw_fall = ~s_q;
        end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end

        rise_en   = (mode_i == EDGE_RISE) || (mode_i == EDGE_BOTH);
        fall_en   = (mode_i == EDGE_FALL) || (mode_i == EDGE_BOTH);
        pos_d     = raw_rise & rise_en;
        neg_d     = raw_fall & fall_en;
        evt       = pos_d | neg_d;
        // A new event wins over a same-cycle clear so nothing is lost
        pending_d = evt | (pending_q & ~clr_i);

        if (clr_i)                    cnt_d = evt ? CNT_W'(1) : '0;
        else if (evt && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
        else                          cnt_d = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q       <= 1'b0;
            level_q   <= 1'b0;
            fcnt_q    <= '0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s_q       <= samp_in;
            level_q   <= level_d;
            fcnt_q    <= fcnt_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign posedge_o = pos_q;
    assign negedge_o = neg_q;
    assign pending_o = pending_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/edge_detector_array.sv
// Array of filtered edge-detector channels with an aggregated registered interrupt.
// Optional EDGE_DET_SYNC_EN adds a 2-flop input synchroniser per channel.
module edge_detector_array
    import edge_det_pkg::*;
#(
    parameter int unsigned CHANNELS    = DEF_CHANNELS,
    parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_edge,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       out_posedge,
    output logic [CHANNELS-1:0]       out_negedge,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS*CNT_W-1:0] evt_cnt,
    output logic                      irq
);

    logic irq_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_det_channel #(
            .FILT_CYCLES (FILT_CYCLES),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .in_i      (in_edge[i]),
            .mode_i    (edge_mode_t'(mode[2*i +: 2])),
            .clr_i     (clr[i]),
            .level_o   (level[i]),
            .posedge_o (out_posedge[i]),
            .negedge_o (out_negedge[i]),
            .pending_o (pending[i]),
            .cnt_o     (evt_cnt[CNT_W*i +: CNT_W])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= |pending;
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_edge_detector_array.sv
// Directed self-checking bench for edge_detector_array (default sizing plus a CNT_W=2 instance).
module tb_edge_detector_array;
    import edge_det_pkg::*;

`ifdef EDGE_DET_SYNC_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_edge;
    logic [15:0] mode;
    logic [7:0]  clr;
    logic [7:0]  level, out_posedge, out_negedge, pending;
    logic [63:0] evt_cnt;
    logic        irq;

    logic        s_in, s_clr;
    logic [1:0]  s_mode;
    logic        s_level, s_pos, s_neg, s_pend, s_irq;
    logic [1:0]  s_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int npos, nneg;

    always #5 clk = ~clk;

    edge_detector_array dut (
        .clk(clk), .rst(rst), .in_edge(in_edge), .mode(mode), .clr(clr),
        .level(level), .out_posedge(out_posedge), .out_negedge(out_negedge),
        .pending(pending), .evt_cnt(evt_cnt), .irq(irq)
    );

    edge_detector_array #(.CHANNELS(1), .FILT_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_edge(s_in), .mode(s_mode), .clr(s_clr),
        .level(s_level), .out_posedge(s_pos), .out_negedge(s_neg),
        .pending(s_pend), .evt_cnt(s_cnt), .irq(s_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] cnt_of(input logic [63:0] v, input int ch);
        logic [63:0] t;
        t = v >> (8 * ch);
        return t[7:0];
    endfunction

    initial begin
        rst = 1'b1; in_edge = '0; mode = '0; clr = '0;
        s_in = 1'b0; s_clr = 1'b0; s_mode = 2'b11;
        step(2);
        check("rst_level", 32'(level), 32'h0);
        check("rst_pulses", 32'({out_posedge, out_negedge}), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_cnt", evt_cnt[31:0] | evt_cnt[63:32], 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        mode[1:0] = 2'(EDGE_RISE);
        step(2);

        // Glitch of FILT_CYCLES-1 samples is rejected
        in_edge[0] = 1'b1; step(3);
        in_edge[0] = 1'b0;
        npos = 0;
        for (int k = 0; k < 8; k++) begin step(1); npos += 32'(out_posedge[0]); end
        check("glitch_level", 32'(level[0]), 32'h0);
        check("glitch_pulses", 32'(npos), 32'h0);
        check("glitch_cnt", 32'(cnt_of(evt_cnt, 0)), 32'h0);

        // Acceptance latency and single-cycle pulse
        in_edge[0] = 1'b1;
        step(LAT);
        check("acc_early", 32'(out_posedge[0]), 32'h0);
        step(1);
        check("acc_pulse", 32'(out_posedge[0]), 32'h1);
        check("acc_level", 32'(level[0]), 32'h1);
        check("acc_pending", 32'(pending[0]), 32'h1);
        check("acc_cnt", 32'(cnt_of(evt_cnt, 0)), 32'h1);
        check("acc_irq_lag", 32'(irq), 32'h0);
        step(1);
        check("acc_pulse_end", 32'(out_posedge[0]), 32'h0);
        check("acc_irq", 32'(irq), 32'h1);

        // Mode gating: ch1 FALL, then OFF
        mode[3:2] = 2'(EDGE_FALL);
        npos = 0; nneg = 0;
        for (int ph = 0; ph < 3; ph++) begin
            in_edge[1] = (ph != 1);
            for (int k = 0; k < 10; k++) begin
                step(1); npos += 32'(out_posedge[1]); nneg += 32'(out_negedge[1]);
            end
        end
        check("fall_pos", 32'(npos), 32'h0);
        check("fall_neg", 32'(nneg), 32'h1);
        check("fall_cnt", 32'(cnt_of(evt_cnt, 1)), 32'h1);
        mode[3:2] = 2'(EDGE_OFF);
        npos = 0; nneg = 0;
        for (int ph = 0; ph < 3; ph++) begin
            in_edge[1] = (ph == 1) ? 1'b1 : 1'b0;
            for (int k = 0; k < 10; k++) begin
                step(1); npos += 32'(out_posedge[1]); nneg += 32'(out_negedge[1]);
            end
            check("off_level_follow", 32'(level[1]), 32'(in_edge[1]));
        end
        check("off_pulses", 32'(npos + nneg), 32'h0);
        check("off_cnt", 32'(cnt_of(evt_cnt, 1)), 32'h1);

        // Saturation on the CNT_W=2 instance
        for (int k = 1; k <= 6; k++) begin
            s_in = ~s_in;
            step(8);
            check("sat_cnt", 32'(s_cnt), (k > 3) ? 32'd3 : 32'(k));
        end

        // Clear collision on ch2 (BOTH): preload count 2, then rise with clr
        clr = 8'b0000_0011; step(1); clr = '0;
        check("clr_cnt0", 32'(cnt_of(evt_cnt, 0)), 32'h0);
        check("clr_pend01", 32'(pending[1:0]), 32'h0);
        mode[5:4] = 2'(EDGE_BOTH);
        in_edge[2] = 1'b1; step(LAT + 3);
        in_edge[2] = 1'b0; step(LAT + 3);
        check("pre_cnt2", 32'(cnt_of(evt_cnt, 2)), 32'h2);
        in_edge[2] = 1'b1; step(LAT);
        clr[2] = 1'b1; step(1);
        check("coll_pending", 32'(pending[2]), 32'h1);
        check("coll_cnt", 32'(cnt_of(evt_cnt, 2)), 32'h1);
        step(1);
        check("clr_pending", 32'(pending[2]), 32'h0);
        check("clr_cnt", 32'(cnt_of(evt_cnt, 2)), 32'h0);
        check("clr_irq_lag", 32'(irq), 32'h1);
        clr[2] = 1'b0; step(1);
        check("clr_irq_drop", 32'(irq), 32'h0);

        // Reset mid-filter with pending set
        mode[7:6] = 2'(EDGE_RISE);
        in_edge[3] = 1'b1; step(LAT + 1);
        check("pre_rst_pend", 32'(pending[3]), 32'h1);
        in_edge[0] = 1'b0; step(LAT - 1);
        in_edge[0] = 1'b1; rst = 1'b1; step(1);
        check("mrst_level", 32'(level), 32'h0);
        check("mrst_pending", 32'(pending), 32'h0);
        check("mrst_cnt", evt_cnt[31:0] | evt_cnt[63:32], 32'h0);
        check("mrst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        step(LAT);
        check("post_rst_early", 32'(out_posedge[0]), 32'h0);
        step(1);
        check("post_rst_pulse", 32'(out_posedge[0]), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
